counter_down_timer: RTL and testbench
=====================================

COUNTER_DOWN_TIMER -- requirements
Module: counter_down_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 3, bit width of the count and load value.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: load_valid  input  1  load request.
REQ-005 SHALL have port: load_ready  output  1  high when a load can be accepted.
REQ-006 SHALL have port: load_value  input  WIDTH  start count; sampled on accept.
REQ-007 SHALL have port: reload  input  1  auto-reload mode; sampled on accept.
REQ-008 SHALL have port: en  input  1  count enable.
REQ-009 SHALL have port: abort  input  1  cancel the running count.
REQ-010 SHALL have port: out  output  WIDTH  registered current count.
REQ-011 SHALL have port: busy  output  1  high while in RUN.
REQ-012 SHALL have port: tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, RUN.
REQ-014 SHALL drive load_ready = (state == IDLE) and busy = (state == RUN), both decoded from registered state only.
REQ-015 A load SHALL be accepted in the cycle where load_valid & load_ready; out = load_value one cycle later.
REQ-016 On accept with load_value != 0: state -> RUN, value and reload flag latched internally, tc = 0.
REQ-017 On accept with load_value == 0: state stays IDLE, out = 0, tc = 1 for one cycle, regardless of reload.
REQ-018 In RUN with en = 1 and out > 1: out decrements by 1 per cycle.
REQ-019 In RUN with en = 1 and out == 1: out = 0 and tc = 1 in the next cycle.
REQ-020 Reload clear, on reaching 0: state -> IDLE on the same edge, so busy = 0 in the same cycle as tc = 1.
REQ-021 Reload set, on reaching 0: state stays RUN; next enabled cycle loads the latched value. The period is latched value + 1 enabled cycles.
REQ-022 In RUN with en = 0: out, state and internal registers hold; tc = 0.
REQ-023 In IDLE, en SHALL be ignored and out SHALL hold its last value.
REQ-024 In RUN with abort = 1: next cycle out = 0, state = IDLE, tc = 0.
REQ-025 abort SHALL take priority over en; abort in IDLE SHALL have no effect.
REQ-026 load_valid during RUN SHALL be ignored (load_ready = 0), including when abort is asserted in the same cycle.
REQ-027 out SHALL never wrap below 0; arithmetic is unsigned modulo 2^WIDTH, but the 0 -> 2^WIDTH-1 transition is unreachable.
REQ-028 tc SHALL be 0 in every cycle not named in REQ-017, REQ-019 or REQ-021.

Reset
REQ-029 rst sampled high SHALL give the following on the next edge, overriding all other inputs: state = IDLE, out = 0, tc = 0, busy = 0, load_ready = 1, latched value = 0, reload flag = 0.
REQ-030 Reset mid-RUN SHALL discard the count without a tc pulse.

Structure
REQ-031 A shared package counter_pkg SHALL hold the state typedef (IDLE, RUN) and the constant DEFAULT_WIDTH = 3.
REQ-032 The design SHALL be a single module with no sub-modules.
REQ-033 The design SHALL separate next-state/next-count combinational logic from one registered update block.

Verification (WIDTH = 3)
REQ-034 Load 5, reload = 0, en = 1 -> out 5,4,3,2,1,0 on consecutive cycles; tc = 1 only with out = 0; busy falls in that same cycle.
REQ-035 Load 3, reload = 1, en = 1 -> out 3,2,1,0,3,2,1,0,...; tc every 4th cycle; busy stays 1.
REQ-036 Load 7, en pattern 1,0,0,1 -> out 7,6,6,6,5; tc = 0 throughout.
REQ-037 Load 6, abort when out = 4 with load_valid also high -> next cycle out = 0, busy = 0, tc = 0, and no load accepted.
REQ-038 Load 0 with reload = 1 -> next cycle out = 0, tc = 1, busy = 0; the cycle after, tc = 0.
REQ-039 rst high while out = 2 in RUN -> next cycle out = 0, busy = 0, tc = 0, load_ready = 1; no later tc.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : counter_pkg
//  Description : Shared types and constants for the down-counting timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

   // Default count width used when the timer is instantiated without override
   localparam int DEFAULT_WIDTH = 3;

   // Timer control state: waiting for a load, or counting down
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_down_timer
//  Description : Loadable down-counter with optional auto-reload, count
//                enable, abort and a registered one-cycle terminal-count pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_down_timer #(
   parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             reload,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             tc
);

   import counter_pkg::*;

   localparam logic [WIDTH-1:0] c_ZERO = '0;
   localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_latched;
   logic             r_reload;
   logic             r_tc;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_latched_nxt;
   logic             w_reload_nxt;
   logic             w_tc_nxt;

   // Next-state and next-count decode; everything holds unless acted upon
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_latched_nxt = r_latched;
      w_reload_nxt  = r_reload;
      w_tc_nxt      = 1'b0;

      case (r_state)
         IDLE: begin
            // en and abort have no meaning while idle; only a load matters
            if (load_valid) begin
               w_count_nxt = load_value;
               if (load_value != c_ZERO) begin
                  w_state_nxt   = RUN;
                  w_latched_nxt = load_value;
                  w_reload_nxt  = reload;
               end else begin
                  // Zero load expires immediately, reload mode notwithstanding
                  w_tc_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               w_count_nxt = c_ZERO;
               w_state_nxt = IDLE;
            end else if (en) begin
               if (r_count > c_ONE) begin
                  w_count_nxt = r_count - c_ONE;
               end else if (r_count == c_ONE) begin
                  w_count_nxt = c_ZERO;
                  w_tc_nxt    = 1'b1;
                  if (!r_reload) begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  // Count sits at zero only in reload mode: restart the period
                  w_count_nxt = r_latched;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Single registered update of all timer state, synchronous reset wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_count   <= c_ZERO;
         r_latched <= c_ZERO;
         r_reload  <= 1'b0;
         r_tc      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_latched <= w_latched_nxt;
         r_reload  <= w_reload_nxt;
         r_tc      <= w_tc_nxt;
      end
   end

   assign load_ready = (r_state == IDLE);
   assign busy       = (r_state == RUN);
   assign out        = r_count;
   assign tc         = r_tc;

endmodule : counter_down_timer
`default_nettype wire

// File: tb/tb_counter_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_down_timer
//  Description : Directed self-checking bench for counter_down_timer (WIDTH=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_down_timer;

   localparam int WIDTH = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             reload;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             tc;

   int errors = 0;
   int checks = 0;

   counter_down_timer #(.WIDTH(WIDTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .reload     (reload),
      .en         (en),
      .abort      (abort),
      .out        (out),
      .busy       (busy),
      .tc         (tc)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Compare all observable outputs at once
   task automatic check_all(input string tag, input int e_out, input int e_busy,
                            input int e_tc, input int e_ready);
      check_val({tag, ".out"},   int'(out),        e_out);
      check_val({tag, ".busy"},  int'(busy),       e_busy);
      check_val({tag, ".tc"},    int'(tc),         e_tc);
      check_val({tag, ".ready"}, int'(load_ready), e_ready);
   endtask

   // Advance one clock and settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_rl [8];
      int tc_rl  [8];
      int exp_en [4];
      int pat_en [4];

      rst = 1'b1; load_valid = 1'b0; load_value = '0;
      reload = 1'b0; en = 1'b0; abort = 1'b0;
      step();
      check_all("reset", 0, 0, 0, 1);
      rst = 1'b0;

      // Load 5, no reload: 5,4,3,2,1,0 with tc and busy falling together
      load_valid = 1'b1; load_value = 3'd5; reload = 1'b0; en = 1'b1;
      step();
      load_valid = 1'b0;
      check_all("l5_acc", 5, 1, 0, 0);
      for (int v = 4; v >= 1; v--) begin
         step();
         check_all($sformatf("l5_%0d", v), v, 1, 0, 0);
      end
      step();
      check_all("l5_end", 0, 0, 1, 1);
      step();
      check_all("l5_post", 0, 0, 0, 1);

      // Load 3 with reload: 3,2,1,0,3,2,1,0 then abort at 2
      exp_rl = '{2, 1, 0, 3, 2, 1, 0, 3};
      tc_rl  = '{0, 0, 1, 0, 0, 0, 1, 0};
      load_valid = 1'b1; load_value = 3'd3; reload = 1'b1; en = 1'b1;
      step();
      load_valid = 1'b0; reload = 1'b0;
      check_all("rl_acc", 3, 1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("rl_%0d", i), exp_rl[i], 1, tc_rl[i], 0);
      end
      step();
      check_all("rl_2", 2, 1, 0, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_all("rl_abort", 0, 0, 0, 1);

      // Load 7, enable pattern 1,0,0,1 gives 6,6,6,5
      pat_en = '{1, 0, 0, 1};
      exp_en = '{6, 6, 6, 5};
      load_valid = 1'b1; load_value = 3'd7; en = 1'b0;
      step();
      load_valid = 1'b0;
      check_all("en_acc", 7, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         en = pat_en[i][0];
         step();
         check_all($sformatf("en_%0d", i), exp_en[i], 1, 0, 0);
      end
      abort = 1'b1; en = 1'b0;
      step();
      abort = 1'b0;
      check_all("en_abort", 0, 0, 0, 1);

      // Load 6, abort at 4 together with a load request that must be dropped
      load_valid = 1'b1; load_value = 3'd6; en = 1'b1;
      step();
      load_valid = 1'b0;
      check_all("ab_acc", 6, 1, 0, 0);
      step();
      step();
      check_all("ab_4", 4, 1, 0, 0);
      abort = 1'b1; load_valid = 1'b1; load_value = 3'd3;
      step();
      abort = 1'b0; load_valid = 1'b0;
      check_all("ab_now", 0, 0, 0, 1);
      step();
      check_all("ab_noload", 0, 0, 0, 1);

      // Zero load with reload: immediate single tc, stays idle
      load_valid = 1'b1; load_value = 3'd0; reload = 1'b1;
      step();
      load_valid = 1'b0; reload = 1'b0;
      check_all("z_acc", 0, 0, 1, 1);
      step();
      check_all("z_post", 0, 0, 0, 1);

      // Abort while idle does not block a load
      abort = 1'b1; load_valid = 1'b1; load_value = 3'd2; en = 1'b1;
      step();
      abort = 1'b0; load_valid = 1'b0;
      check_all("ia_acc", 2, 1, 0, 0);
      step();
      check_all("ia_1", 1, 1, 0, 0);
      step();
      check_all("ia_end", 0, 0, 1, 1);

      // Reset mid-run at count 2: discarded, no terminal pulse afterwards
      load_valid = 1'b1; load_value = 3'd4; en = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      step();
      check_all("rs_2", 2, 1, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all("rs_now", 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("rs_after_%0d", i), 0, 0, 0, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_counter_down_timer
`default_nettype wire
